// File: rtl/fifo_modport.sv
// Single-clock 32x32 FIFO with registered write-side status (full, almost-full,
// overflow pulse, occupancy, free level) and a same-clock read port for draining.
module fifo_modport #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  wclk,
    input  logic                  hw_rst_n,
    input  logic                  mem_rst,
    input  logic                  sw_rst,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] afull_value,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rempty,
    output logic                  wfull,
    output logic                  wr_almost_ful,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   fifo_write_count,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam logic [ADDR_WIDTH:0]   C_DEPTH   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] C_PTR_ONE = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_level;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rempty;
    logic                  r_wfull;
    logic                  r_afull;
    logic                  r_overflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_drop;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    // Request semantics: a write is taken when write_enable is high and the FIFO
    // is not full at the edge, otherwise it is dropped and overflow pulses; a read
    // is taken when read_enable is high and the FIFO is not empty. No backpressure
    // beyond the status flags; sw_rst suppresses both requests.
    always_comb begin
        w_full      = (r_count == C_DEPTH);
        w_empty     = (r_count == '0);
        w_wr_acc    = write_enable && !w_full && !sw_rst;
        w_rd_acc    = read_enable && !w_empty && !sw_rst;
        w_drop      = write_enable && w_full && !sw_rst;
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + C_CNT_ONE;
            2'b01:   w_count_nxt = r_count - C_CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // The write is scheduled after the clear so it survives a same-cycle mem_rst.
    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (mem_rst) begin
                for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            end
            if (w_wr_acc) r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge wclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_level    <= C_DEPTH;
            r_rdata    <= '0;
            r_rempty   <= 1'b1;
            r_wfull    <= 1'b0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else if (sw_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_level    <= C_DEPTH;
            r_rempty   <= 1'b1;
            r_wfull    <= 1'b0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) r_wptr <= r_wptr + C_PTR_ONE;
            if (w_rd_acc) begin
                r_rptr  <= r_rptr + C_PTR_ONE;
                r_rdata <= r_mem[r_rptr];
            end
            r_count    <= w_count_nxt;
            r_level    <= C_DEPTH - w_count_nxt;
            r_rempty   <= (w_count_nxt == '0);
            r_wfull    <= (w_count_nxt == C_DEPTH);
            r_afull    <= (w_count_nxt >= {1'b0, afull_value});
            r_overflow <= w_drop;
        end
    end

    assign rdata            = r_rdata;
    assign rempty           = r_rempty;
    assign wfull            = r_wfull;
    assign wr_almost_ful    = r_afull;
    assign overflow         = r_overflow;
    assign fifo_write_count = r_count;
    assign wr_level         = r_level;

endmodule

// File: tb/tb_fifo_modport.sv
// Directed bench for fifo_modport: a queue model of FIFO contents predicts
// data and every status flag after each clock edge.
module tb_fifo_modport;

    logic        wclk;
    logic        hw_rst_n;
    logic        mem_rst;
    logic        sw_rst;
    logic [31:0] wdata;
    logic        write_enable;
    logic [4:0]  afull_value;
    logic        read_enable;
    logic [31:0] rdata;
    logic        rempty;
    logic        wfull;
    logic        wr_almost_ful;
    logic        overflow;
    logic [5:0]  fifo_write_count;
    logic [5:0]  wr_level;

    fifo_modport dut (
        .wclk             (wclk),
        .hw_rst_n         (hw_rst_n),
        .mem_rst          (mem_rst),
        .sw_rst           (sw_rst),
        .wdata            (wdata),
        .write_enable     (write_enable),
        .afull_value      (afull_value),
        .read_enable      (read_enable),
        .rdata            (rdata),
        .rempty           (rempty),
        .wfull            (wfull),
        .wr_almost_ful    (wr_almost_ful),
        .overflow         (overflow),
        .fifo_write_count (fifo_write_count),
        .wr_level         (wr_level)
    );

    // clock
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // scoreboard state
    logic [31:0] exp_q[$];
    logic [31:0] m_rdata;
    logic        m_ovf;
    logic        m_afull;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_status(input string tag);
        int sz;
        sz = exp_q.size();
        check({tag, ".count"}, 32'(fifo_write_count), 32'(sz));
        check({tag, ".level"}, 32'(wr_level), 32'(32 - sz));
        check({tag, ".wfull"}, 32'(wfull), 32'(sz == 32));
        check({tag, ".rempty"}, 32'(rempty), 32'(sz == 0));
        check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".afull"}, 32'(wr_almost_ful), 32'(m_afull));
        check({tag, ".rdata"}, rdata, m_rdata);
        check({tag, ".sum"}, 32'(fifo_write_count) + 32'(wr_level), 32'd32);
    endtask

    // One clock with the given requests; model is updated, then outputs checked.
    task automatic cycle(input string tag, input logic we, input logic [31:0] wd,
                         input logic re, input logic sr, input logic mr);
        logic wr_acc, rd_acc;
        write_enable = we;
        wdata        = wd;
        read_enable  = re;
        sw_rst       = sr;
        mem_rst      = mr;
        wr_acc = we && (exp_q.size() < 32) && !sr;
        rd_acc = re && (exp_q.size() > 0) && !sr;
        m_ovf  = we && (exp_q.size() == 32) && !sr;
        if (rd_acc) begin
            m_rdata = exp_q[0];
            void'(exp_q.pop_front());
        end
        if (sr) exp_q.delete();
        if (mr) begin
            foreach (exp_q[i]) exp_q[i] = '0;
        end
        if (wr_acc) exp_q.push_back(wd);
        m_afull = sr ? 1'b0 : (exp_q.size() >= int'(afull_value));
        @(posedge wclk);
        #1;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        sw_rst       = 1'b0;
        mem_rst      = 1'b0;
        check_status(tag);
    endtask

    task automatic wr(input logic [31:0] wd);
        cycle("write", 1'b1, wd, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rd();
        cycle("read", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        hw_rst_n = 1'b0;
        mem_rst = 1'b0;
        sw_rst = 1'b0;
        wdata = '0;
        write_enable = 1'b0;
        read_enable = 1'b0;
        afull_value = 5'd28;
        m_rdata = '0;
        m_ovf = 1'b0;
        m_afull = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        check_status("reset");
        hw_rst_n = 1'b1;

        // fill 0..31, almost-full rises on the 28th write
        for (int i = 0; i < 32; i++) begin
            wr(32'(i));
            if (i == 26) check("afull_before_28", 32'(wr_almost_ful), 32'd0);
            if (i == 27) check("afull_at_28", 32'(wr_almost_ful), 32'd1);
        end
        check("full_after_32", 32'(wfull), 32'd1);

        // overflow pulse
        wr(32'hDEAD);
        check("ovf_pulse", 32'(overflow), 32'd1);
        cycle("idle", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ovf_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd();
            check("drain_order", rdata, 32'(i));
        end

        // wrap-around ordering
        for (int i = 0; i < 20; i++) wr(32'(200 + i));
        for (int i = 0; i < 20; i++) rd();
        for (int i = 0; i < 32; i++) wr(32'(100 + i));
        for (int i = 0; i < 32; i++) rd();
        check("wrap_empty", 32'(rempty), 32'd1);

        // simultaneous access at full, then at empty
        for (int i = 0; i < 32; i++) wr(32'(300 + i));
        cycle("rw_full", 1'b1, 32'hBEEF, 1'b1, 1'b0, 1'b0);
        check("rw_full_count", 32'(fifo_write_count), 32'd31);
        check("rw_full_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 31; i++) rd();
        cycle("rw_empty", 1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
        check("rw_empty_count", 32'(fifo_write_count), 32'd1);
        check("rw_empty_rdata", rdata, 32'(331));
        rd();

        // soft reset with 5 stored and a write in the same cycle
        for (int i = 0; i < 5; i++) wr(32'(400 + i));
        cycle("sw_rst", 1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
        check("sw_rst_count", 32'(fifo_write_count), 32'd0);

        // memory clear with 5 stored, then clear racing a write
        for (int i = 0; i < 5; i++) wr(32'(500 + i));
        cycle("mem_rst", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("mem_rst_count", 32'(fifo_write_count), 32'd5);
        for (int i = 0; i < 5; i++) rd();
        for (int i = 0; i < 3; i++) wr(32'(600 + i));
        cycle("mem_rst_wr", 1'b1, 32'h55, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) rd();
        check("mem_rst_write_wins", rdata, 32'h55);

        // threshold changes take effect at the next edge
        afull_value = 5'd0;
        cycle("afull0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("afull_zero", 32'(wr_almost_ful), 32'd1);
        afull_value = 5'd3;
        cycle("afull3", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) wr(32'(700 + i));
        check("afull_three", 32'(wr_almost_ful), 32'd1);
        for (int i = 0; i < 3; i++) rd();

        // asynchronous reset mid-operation with 10 stored
        afull_value = 5'd28;
        for (int i = 0; i < 10; i++) wr(32'(800 + i));
        @(negedge wclk);
        hw_rst_n = 1'b0;
        #1;
        exp_q.delete();
        m_rdata = '0;
        m_ovf = 1'b0;
        m_afull = 1'b0;
        check_status("hw_rst_async");
        @(posedge wclk);
        #1;
        hw_rst_n = 1'b1;
        rd();
        check("post_rst_empty", 32'(rempty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
